tl_dll_tx_vc_arb: RTL and testbench

Parametrised transmit-side successor of the TL/DLL boundary: accepts TLP word streams from up to N_VC transaction-layer virtual channels, buffers each in a per-VC store-and-forward FIFO, and arbitrates complete TLPs round-robin onto the single DLL transmit port. The block adds VC tagging (`vc_num`), `last` framing, and gating by `linkup` and per-VC `dll_vc_up`. It sits between the TL packet generators and the DLL TX input.

---
 rtl/tl_dll_tx_vc_arb.sv | 175 +++++++++++++++++
 tb/tb_tl_dll_tx_vc_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_dll_tx_vc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tl_dll_tx_vc_arb
// Purpose  : Per-VC store-and-forward TLP FIFOs with round-robin whole-TLP
//            arbitration onto the DLL transmit port.
//            Option macro TL_DLL_TX_LINKDOWN_FLUSH_EN: flush on linkup fall.
// Revision : 1.0 - initial release
// ============================================================================
module tl_dll_tx_vc_arb #(
  parameter int DATA_W = 32,
  parameter int N_VC   = 8,
  parameter int DEPTH  = 16,
  parameter int VC_W   = (N_VC > 1) ? $clog2(N_VC) : 1
) (
  input  logic                   tl_dll_clk,
  input  logic                   arst,
  input  logic                   linkup,
  input  logic [N_VC-1:0]        dll_vc_up,
  input  logic [N_VC*DATA_W-1:0] tl_data_i,
  input  logic [N_VC-1:0]        tl_valid_i,
  input  logic [N_VC-1:0]        tl_last_i,
  output logic [N_VC-1:0]        tl_ready_o,
  output logic [DATA_W-1:0]      tx_data_o,
  output logic                   tx_valid_o,
  output logic                   tx_last_o,
  input  logic                   tx_ready_i,
  output logic [VC_W-1:0]        vc_num,
  output logic [N_VC-1:0]        tlp_pending_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
  localparam logic [VC_W:0] c_NVC_EXT = (VC_W + 1)'(N_VC);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]      r_state;
  logic [VC_W-1:0] r_last_grant;
  logic [N_VC-1:0] w_push;
  logic [N_VC-1:0] w_pop;
  logic [N_VC-1:0] w_eligible;
  logic [DATA_W:0] w_head [N_VC];
  logic            w_flush;
  logic            w_any_elig;
  logic [VC_W-1:0] w_grant;
  logic [VC_W:0]   w_idx;
  logic            w_head_last;

`ifdef TL_DLL_TX_LINKDOWN_FLUSH_EN
  logic r_linkup_d;

  always_ff @(posedge tl_dll_clk or posedge arst) begin
    if (arst) begin
      r_linkup_d <= 1'b0;
    end else begin
      r_linkup_d <= linkup;
    end
  end

  assign w_flush = r_linkup_d & ~linkup;
`else
  assign w_flush = 1'b0;
`endif

  for (genvar gi = 0; gi < N_VC; gi++) begin : g_vc
    logic [DATA_W:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_tlp_cnt;
    logic                 w_push_last;
    logic                 w_pop_last;

    // Ready looks only at the registered count, so a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign tl_ready_o[gi]    = (r_count < c_DEPTH_CNT);
    assign w_push[gi]        = tl_valid_i[gi] & tl_ready_o[gi] & ~w_flush;
    assign w_pop[gi]         = (r_state == S_SEND) & (vc_num == VC_W'(gi)) & tx_ready_i;
    assign w_head[gi]        = r_mem[r_rptr];
    assign w_push_last       = w_push[gi] & tl_last_i[gi];
    assign w_pop_last        = w_pop[gi] & w_head[gi][DATA_W];
    assign tlp_pending_o[gi] = (r_tlp_cnt != '0);
    assign w_eligible[gi]    = linkup & dll_vc_up[gi] & tlp_pending_o[gi];

    always_ff @(posedge tl_dll_clk) begin
      if (w_push[gi]) begin
        r_mem[r_wptr] <= {tl_last_i[gi], tl_data_i[gi*DATA_W +: DATA_W]};
      end
    end

    always_ff @(posedge tl_dll_clk or posedge arst) begin
      if (arst) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_tlp_cnt <= '0;
      end else if (w_flush) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_tlp_cnt <= '0;
      end else begin
        if (w_push[gi]) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop[gi]) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        case ({w_push_last, w_pop_last})
          2'b10:   r_tlp_cnt <= r_tlp_cnt + 1'b1;
          2'b01:   r_tlp_cnt <= r_tlp_cnt - 1'b1;
          default: r_tlp_cnt <= r_tlp_cnt;
        endcase
      end
    end
  end

  // Round-robin search starting one past the previous grant.
  always_comb begin
    w_any_elig = 1'b0;
    w_grant    = '0;
    w_idx      = '0;
    for (int k = 1; k <= N_VC; k++) begin
      w_idx = {1'b0, r_last_grant} + (VC_W + 1)'(k);
      if (w_idx >= c_NVC_EXT) begin
        w_idx = w_idx - c_NVC_EXT;
      end
      if (!w_any_elig && w_eligible[w_idx[VC_W-1:0]]) begin
        w_any_elig = 1'b1;
        w_grant    = w_idx[VC_W-1:0];
      end
    end
  end

  assign w_head_last = w_head[vc_num][DATA_W];

  always_ff @(posedge tl_dll_clk or posedge arst) begin
    if (arst) begin
      r_state      <= S_IDLE;
      r_last_grant <= VC_W'(N_VC - 1);
      vc_num       <= '0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_elig) begin
            r_state      <= S_SEND;
            vc_num       <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        S_SEND: begin
          if (tx_ready_i && w_head_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid_o = (r_state == S_SEND);
  assign tx_data_o  = tx_valid_o ? w_head[vc_num][DATA_W-1:0] : '0;
  assign tx_last_o  = tx_valid_o & w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_tl_dll_tx_vc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_dll_tx_vc_arb
// Purpose  : Directed self-checking bench for tl_dll_tx_vc_arb (8 VC, depth 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_dll_tx_vc_arb;

  logic          tl_dll_clk = 1'b0;
  logic          arst;
  logic          linkup;
  logic [7:0]    dll_vc_up;
  logic [255:0]  tl_data;
  logic [7:0]    tl_valid;
  logic [7:0]    tl_last;
  logic [7:0]    tl_ready;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready;
  logic [2:0]    vc_num;
  logic [7:0]    tlp_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] mon_data [$];
  logic        mon_last [$];
  logic [2:0]  mon_vc   [$];
  int          mon_cyc  [$];

  tl_dll_tx_vc_arb #(.DATA_W(32), .N_VC(8), .DEPTH(16)) dut (
    .tl_dll_clk    (tl_dll_clk),
    .arst          (arst),
    .linkup        (linkup),
    .dll_vc_up     (dll_vc_up),
    .tl_data_i     (tl_data),
    .tl_valid_i    (tl_valid),
    .tl_last_i     (tl_last),
    .tl_ready_o    (tl_ready),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_last_o     (tx_last),
    .tx_ready_i    (tx_ready),
    .vc_num        (vc_num),
    .tlp_pending_o (tlp_pending)
  );

  always #5 tl_dll_clk = ~tl_dll_clk;

  always @(posedge tl_dll_clk) cyc <= cyc + 1;

  // Log every accepted DLL word, sampled mid-cycle.
  always @(negedge tl_dll_clk) begin
    if (!arst && tx_valid && tx_ready) begin
      mon_data.push_back(tx_data);
      mon_last.push_back(tx_last);
      mon_vc.push_back(vc_num);
      mon_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tl_dll_clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_last.delete();
    mon_vc.delete();
    mon_cyc.delete();
  endtask

  task automatic push(input int vc, input int n, input logic [31:0] base);
    for (int j = 0; j < n; j++) begin
      tl_valid[vc]          = 1'b1;
      tl_data[vc*32 +: 32]  = base + j;
      tl_last[vc]           = (j == n - 1);
      step();
    end
    tl_valid[vc] = 1'b0;
    tl_last[vc]  = 1'b0;
  endtask

  task automatic wait_words(input int n, input string tag);
    int budget;
    budget = 200;
    while (mon_data.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (mon_data.size() < n) check(tag, mon_data.size(), n);
  endtask

  initial begin
    arst      = 1'b1;
    linkup    = 1'b1;
    dll_vc_up = 8'hFF;
    tl_data   = '0;
    tl_valid  = '0;
    tl_last   = '0;
    tx_ready  = 1'b1;

    @(negedge tl_dll_clk);
    check("rst_valid",   tx_valid, 0);
    check("rst_data",    tx_data, 0);
    check("rst_last",    tx_last, 0);
    check("rst_vc",      vc_num, 0);
    check("rst_ready",   tl_ready, 8'hFF);
    check("rst_pending", tlp_pending, 0);
    step();
    arst = 1'b0;
    step();

    // Single VC0 3-word TLP, latency and ordering
    clear_mon();
    push(0, 3, 32'hA0);
    @(negedge tl_dll_clk);
    check("t1_pend_c1",  tlp_pending, 8'h01);
    check("t1_valid_c1", tx_valid, 0);
    step();
    @(negedge tl_dll_clk);
    check("t1_valid_c2", tx_valid, 1);
    check("t1_data_c2",  tx_data, 32'hA0);
    wait_words(3, "t1_timeout");
    check("t1_w0", mon_data[0], 32'hA0);
    check("t1_w1", mon_data[1], 32'hA1);
    check("t1_w2", mon_data[2], 32'hA2);
    check("t1_lastflags", {mon_last[0], mon_last[1], mon_last[2]}, 3'b001);
    check("t1_vc", mon_vc[2], 0);
    @(negedge tl_dll_clk);
    check("t1_idle_after", tx_valid, 0);
    check("t1_pend_after", tlp_pending, 0);
    step();

    // Round-robin VC1, VC3, VC5 then wrap
    clear_mon();
    dll_vc_up = 8'h00;
    push(1, 2, 32'h10);
    push(3, 2, 32'h30);
    push(5, 2, 32'h50);
    @(negedge tl_dll_clk);
    check("t2_pending", tlp_pending, 8'h2A);
    check("t2_no_tx", tx_valid, 0);
    step();
    dll_vc_up = 8'hFF;
    wait_words(6, "t2_timeout");
    check("t2_vc_a", mon_vc[0], 1);
    check("t2_vc_b", mon_vc[2], 3);
    check("t2_vc_c", mon_vc[4], 5);
    check("t2_data", mon_data[3], 32'h31);
    check("t2_last", {mon_last[0], mon_last[1]}, 2'b01);
    check("t2_bubble", mon_cyc[2] - mon_cyc[1], 2);
    step();
    dll_vc_up = 8'h00;
    push(3, 2, 32'h32);
    push(1, 2, 32'h12);
    dll_vc_up = 8'hFF;
    wait_words(10, "t2_wrap_timeout");
    check("t2_wrap_vc1", mon_vc[6], 1);
    check("t2_wrap_d",   mon_data[6], 32'h12);
    check("t2_wrap_vc3", mon_vc[8], 3);
    step();
    step();

    // Backpressure for 5 cycles mid-TLP
    clear_mon();
    push(0, 4, 32'hB0);
    wait_words(1, "t3_first_timeout");
    tx_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge tl_dll_clk);
      check("t3_hold_valid", tx_valid, 1);
      check("t3_hold_data",  tx_data, 32'hB1);
      step();
    end
    tx_ready = 1'b1;
    wait_words(4, "t3_timeout");
    step();
    step();
    check("t3_count", mon_data.size(), 4);
    check("t3_w1", mon_data[1], 32'hB1);
    check("t3_w3", mon_data[3], 32'hB3);
    check("t3_last", {mon_last[2], mon_last[3]}, 2'b01);

    // Full VC2 held by dll_vc_up, then released
    clear_mon();
    dll_vc_up = 8'hFB;
    push(2, 16, 32'hC0);
    @(negedge tl_dll_clk);
    check("t4_full_ready", tl_ready[2], 0);
    check("t4_pending", tlp_pending[2], 1);
    check("t4_no_tx", tx_valid, 0);
    step();
    step();
    @(negedge tl_dll_clk);
    check("t4_still_no_tx", tx_valid, 0);
    step();
    dll_vc_up = 8'hFF;
    wait_words(1, "t4_first_timeout");
    @(negedge tl_dll_clk);
    check("t4_ready_back", tl_ready[2], 1);
    wait_words(16, "t4_timeout");
    check("t4_first", mon_data[0], 32'hC0);
    check("t4_final", mon_data[15], 32'hCF);
    check("t4_lastflags", {mon_last[14], mon_last[15]}, 2'b01);
    check("t4_vc", mon_vc[15], 2);
    step();
    step();

    // linkup drop after word 2 of a 4-word TLP, another TLP waiting on VC4
    clear_mon();
    dll_vc_up = 8'hEF;
    push(4, 2, 32'hE0);
    push(6, 4, 32'hD0);
    wait_words(2, "t5_start_timeout");
    check("t5_vc", mon_vc[0], 6);
    linkup    = 1'b0;
    dll_vc_up = 8'hFF;
`ifdef TL_DLL_TX_LINKDOWN_FLUSH_EN
    step();
    @(negedge tl_dll_clk);
    check("t5_flush_valid", tx_valid, 0);
    check("t5_flush_pend",  tlp_pending, 0);
    check("t5_flush_ready", tl_ready, 8'hFF);
    check("t5_flush_count", mon_data.size(), 3);
    step();
    linkup = 1'b1;
    step();
    step();
`else
    wait_words(4, "t5_tail_timeout");
    for (int s = 0; s < 6; s++) step();
    @(negedge tl_dll_clk);
    check("t5_count", mon_data.size(), 4);
    check("t5_w3", mon_data[3], 32'hD3);
    check("t5_last", mon_last[3], 1);
    check("t5_no_grant", tx_valid, 0);
    check("t5_vc4_held", tlp_pending[4], 1);
    step();
    linkup = 1'b1;
    wait_words(6, "t5_resume_timeout");
    check("t5_resume_vc", mon_vc[4], 4);
    check("t5_resume_d", mon_data[5], 32'hE1);
    step();
    step();
`endif

    // Asynchronous reset mid-SEND discards everything
    clear_mon();
    dll_vc_up = 8'h00;
    push(1, 2, 32'h90);
    push(7, 3, 32'hF0);
    dll_vc_up = 8'hFF;
    wait_words(1, "t6_start_timeout");
    check("t6_vc", mon_vc[0], 7);
    #2;
    arst = 1'b1;
    #1;
    check("t6_valid", tx_valid, 0);
    check("t6_data",  tx_data, 0);
    check("t6_last",  tx_last, 0);
    check("t6_vcnum", vc_num, 0);
    check("t6_pend",  tlp_pending, 0);
    check("t6_ready", tl_ready, 8'hFF);
    step();
    arst = 1'b0;
    clear_mon();
    for (int s = 0; s < 10; s++) step();
    check("t6_no_words", mon_data.size(), 0);
    check("t6_pend_after", tlp_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
